rst_seq: RTL and testbench
==========================

# rst_seq

Parametrised reset sequencer for the multi-domain design. It takes the raw push-button reset and synchronises it into `clk` with a configurable synchroniser depth. It then debounces the button's release and releases `NUM_CH` active-low reset outputs one at a time, in order, with a fixed gap between them. Assertion is simultaneous on all channels. It replaces the fixed two-flop synchroniser wherever more than one reset consumer must come out of reset in a defined order.

## Interface
- `NUM_CH`, 4: number of sequenced reset outputs (≥1).
- `SYNC_STAGES`, 2: synchroniser flop count on `RST_n` (≥2).
- `FILT_CYCLES`, 16: cycles `RST_n` must stay high (synchronised) before sequencing starts (≥1).
- `GAP_CYCLES`, 8: cycles between successive channel releases (≥1).
- `clk` input 1: single clock; all flops posedge.
- `rst` input 1: reset, synchronous, active-high; overrides everything.
- `RST_n` input 1: raw asynchronous push-button reset, active-low.
- `soft_rst` input 1: synchronous active-high restart pulse; present only with `RST_SEQ_SOFT_EN`.
- `rst_n_out` output `NUM_CH`: active-low resets; bit 0 is released first.
- `seq_done` output 1: high once all channels are released.

## Operation
- **Synchroniser.** `SYNC_STAGES` flops, reset to 0; the last stage is `btn_s`.
- **States:**
  - `HOLD`: all outputs 0; counters 0. If `btn_s`=1, go to `FILTER`.
  - `FILTER`: `filt_cnt` increments each cycle. At `filt_cnt`==`FILT_CYCLES-1`, go to `RELEASE` with `idx`=0 and `gap_cnt`=0.
  - `RELEASE`: `gap_cnt` increments. At `gap_cnt`==`GAP_CYCLES-1`:
    - `rst_n_out[idx]` is set to 1.
    - `gap_cnt` is cleared and `idx` increments.
    - If `idx`==`NUM_CH-1`, go to `RUN` and set `seq_done`=1 on the same edge.
  - `RUN`: all outputs 1, `seq_done`=1; holds.
- **Button low.** `btn_s`=0 in any state forces `HOLD` on the next edge: all `rst_n_out`=0, `seq_done`=0, counters cleared. A bounce during `FILTER` therefore restarts the filter from 0.
- **Released channels stay released.** A released channel stays 1 until `HOLD` is re-entered. Channels are never deasserted individually.
- **Counter widths.**
  - Counters are `$clog2` of their terminal value, minimum 1 bit.
  - `idx` is `$clog2(NUM_CH)`, minimum 1 bit.
  - No counter wraps; each is cleared on terminal count or on entering `HOLD`.
- **`rst`.** `rst`=1 clears the synchroniser, state (`HOLD`), counters and all outputs on that edge. After `rst` drops, the sequence restarts naturally if `RST_n` is high.

## Timing
- **Reset values.** `rst_n_out`=0 on all bits, `seq_done`=0, state `HOLD`, synchroniser all 0.
- **Edge 0.** Edge 0 is the first edge sampling `RST_n`=1 into stage 1.
- **Release latency.** Channel i rises at edge `SYNC_STAGES` + `FILT_CYCLES` + (i+1)·`GAP_CYCLES`. `seq_done` rises with the last channel.
- **Assertion latency.** With edge 0 as the first edge sampling `RST_n`=0, all channels and `seq_done` fall at edge `SYNC_STAGES`.
- **Release vs. assertion.** If `btn_s` falls on the same cycle a release would occur, assertion wins and nothing is released.
- **`rst` priority.** `rst` has priority over `btn_s` and over `soft_rst`.

## Configuration
- **`RST_SEQ_SOFT_EN` defined:**
  - `soft_rst` port exists.
  - `soft_rst`=1 behaves exactly as `btn_s`=0 for one cycle: `HOLD` and all outputs 0 on the next edge.
  - If `btn_s` is still 1, `FILTER` is entered on the following edge and the full filter-plus-release sequence reruns.
  - `soft_rst` held high keeps the block in `HOLD`.
- **`RST_SEQ_SOFT_EN` undefined:** the port and logic are absent; behaviour is otherwise identical.

## Test plan
1. **Reset values.** Defaults; hold `rst`=1 for 3 cycles with `RST_n`=1 → all outputs 0 and `seq_done`=0 during reset.
2. **Nominal release.** Defaults; release `rst` with `RST_n`=1 (edge 0 is the first edge after `rst` falls) → `rst_n_out` goes 0001 at edge 26, 0011 at edge 34, 0111 at edge 42, 1111 with `seq_done`=1 at edge 50.
3. **Bounce during filter.** `RST_n` high for 10 cycles, low 1 cycle, then high → filter restarts; channel 0 rises 26 edges after the final rising sample.
4. **Assertion mid-sequence.** Drop `RST_n` at edge 38 (`rst_n_out`=0011) → all outputs 0 at edge 40; no further releases; the sequence reruns after `RST_n` returns high.
5. **Simultaneous events.** Assert `rst` on the same cycle `RST_n` falls, in `RUN` → outputs 0 on that edge. `RST_n` falls on the edge channel 2 would rise → channel 2 never rises.
6. **Soft restart.** With `RST_SEQ_SOFT_EN`, pulse `soft_rst` one cycle in `RUN` → outputs 0 next edge; channel 0 rises 1+16+8 = 25 edges after the pulse edge; channel 3 rises at 49.

Source files
------------

// File: rtl/rst_seq.sv
// rst_seq: synchronises the push-button RST_n, filters its release and then
// releases NUM_CH active-low resets in order. Define RST_SEQ_SOFT_EN for soft_rst.
module rst_seq #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 16,
  parameter int GAP_CYCLES  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RST_n,
`ifdef RST_SEQ_SOFT_EN
  input  logic              soft_rst,
`endif
  output logic [NUM_CH-1:0] rst_n_out,
  output logic              seq_done
);

  localparam int FILT_W = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILT_CYCLES - 1);
  localparam logic [FILT_W-1:0] FILT_ONE  = FILT_W'(1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_ONE   = GAP_W'(1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_CH - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    FILTER  = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   btn_s;
  logic                   soft_s;
  logic                   abort_s;
  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [FILT_W-1:0]      filt_cnt_r;
  logic [FILT_W-1:0]      filt_cnt_nxt_s;
  logic [GAP_W-1:0]       gap_cnt_r;
  logic [GAP_W-1:0]       gap_cnt_nxt_s;
  logic [IDX_W-1:0]       idx_r;
  logic [IDX_W-1:0]       idx_nxt_s;
  logic [NUM_CH-1:0]      out_r;
  logic [NUM_CH-1:0]      out_nxt_s;
  logic [NUM_CH-1:0]      release_mask_s;
  logic                   done_r;
  logic                   done_nxt_s;
  logic                   filt_last_s;
  logic                   gap_last_s;
  logic                   idx_last_s;

`ifdef RST_SEQ_SOFT_EN
  assign soft_s = soft_rst;
`else
  assign soft_s = 1'b0;
`endif

  assign btn_s       = sync_r[SYNC_STAGES-1];
  // A low button or a soft restart both force HOLD, ahead of any pending release.
  assign abort_s     = ~btn_s | soft_s;
  assign filt_last_s = (filt_cnt_r == FILT_LAST);
  assign gap_last_s  = (gap_cnt_r == GAP_LAST);
  assign idx_last_s  = (idx_r == IDX_LAST);

  // Synchroniser shift register for the raw button.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], RST_n};
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= HOLD;
      filt_cnt_r <= {FILT_W{1'b0}};
      gap_cnt_r  <= {GAP_W{1'b0}};
      idx_r      <= {IDX_W{1'b0}};
      out_r      <= {NUM_CH{1'b0}};
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      filt_cnt_r <= filt_cnt_nxt_s;
      gap_cnt_r  <= gap_cnt_nxt_s;
      idx_r      <= idx_nxt_s;
      out_r      <= out_nxt_s;
      done_r     <= done_nxt_s;
    end
  end

  // Next-state selection.
  always_comb begin
    state_nxt_s = state_r;
    if (abort_s) begin
      state_nxt_s = HOLD;
    end else begin
      case (state_r)
        HOLD:    state_nxt_s = FILTER;
        FILTER:  state_nxt_s = filt_last_s ? RELEASE : FILTER;
        RELEASE: state_nxt_s = (gap_last_s && idx_last_s) ? RUN : RELEASE;
        RUN:     state_nxt_s = RUN;
        default: state_nxt_s = HOLD;
      endcase
    end
  end

  // One-hot mask of the channel released at the end of the current gap.
  always_comb begin
    release_mask_s = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      release_mask_s[i] = (idx_r == IDX_W'(i));
    end
  end

  // Counter and output next values; released channels accumulate until HOLD.
  always_comb begin
    filt_cnt_nxt_s = {FILT_W{1'b0}};
    gap_cnt_nxt_s  = {GAP_W{1'b0}};
    idx_nxt_s      = {IDX_W{1'b0}};
    out_nxt_s      = {NUM_CH{1'b0}};
    done_nxt_s     = 1'b0;
    if (!abort_s) begin
      case (state_r)
        FILTER: begin
          filt_cnt_nxt_s = filt_last_s ? {FILT_W{1'b0}} : (filt_cnt_r + FILT_ONE);
        end
        RELEASE: begin
          if (gap_last_s) begin
            out_nxt_s  = out_r | release_mask_s;
            idx_nxt_s  = idx_last_s ? {IDX_W{1'b0}} : (idx_r + IDX_ONE);
            done_nxt_s = idx_last_s;
          end else begin
            out_nxt_s     = out_r;
            gap_cnt_nxt_s = gap_cnt_r + GAP_ONE;
            idx_nxt_s     = idx_r;
          end
        end
        RUN: begin
          out_nxt_s  = {NUM_CH{1'b1}};
          done_nxt_s = 1'b1;
        end
        default: begin
          out_nxt_s  = {NUM_CH{1'b0}};
          done_nxt_s = 1'b0;
        end
      endcase
    end else begin
      out_nxt_s  = {NUM_CH{1'b0}};
      done_nxt_s = 1'b0;
    end
  end

  assign rst_n_out = out_r;
  assign seq_done  = done_r;

endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: directed vector table, hand sequences and random stimulus
// checked against a run-length model of the sequencer (defaults parameters).
module tb_rst_seq;

  localparam int N = 4;
  localparam int S = 2;
  localparam int F = 16;
  localparam int G = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         RST_n = 1'b1;
  logic         soft_rst = 1'b0;
  logic [N-1:0] rst_n_out;
  logic         seq_done;

  int checks = 0;
  int errors = 0;

  rst_seq #(.NUM_CH(N), .SYNC_STAGES(S), .FILT_CYCLES(F), .GAP_CYCLES(G)) dut (
    .clk       (clk),
    .rst       (rst),
    .RST_n     (RST_n),
`ifdef RST_SEQ_SOFT_EN
    .soft_rst  (soft_rst),
`endif
    .rst_n_out (rst_n_out),
    .seq_done  (seq_done)
  );

  always #5 clk = ~clk;

  // Reference model: h = number of consecutive high button samples that have
  // reached the sequencer; channel i is out of reset once h > F + (i+1)*G.
  int h = 0;
  bit dq[$];
  initial begin
    bit b;
    logic [N-1:0] exp_out;
    logic         exp_done;
    forever begin
      @(posedge clk);
      if (rst) begin
        dq = {};
        repeat (S) dq.push_back(1'b0);
        h = 0;
      end else begin
        dq.push_back(RST_n);
        b = dq.pop_front();
        if (!b || soft_rst) h = 0;
        else if (h < 100000) h++;
      end
      #1;
      for (int i = 0; i < N; i++) exp_out[i] = (h >= F + (i + 1) * G + 1);
      exp_done = (h >= F + N * G + 1);
      checks++;
      if (rst_n_out !== exp_out || seq_done !== exp_done) begin
        errors++;
        $display("FAIL model t=%0t: got out=%b done=%b, want out=%b done=%b",
                 $time, rst_n_out, seq_done, exp_out, exp_done);
      end
    end
  end

  typedef struct {
    logic         rst_v;
    logic         btn_v;
    int           cycles;
    logic [N-1:0] exp_out;
    logic         exp_done;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [N-1:0] eo, input logic ed);
    checks++;
    if (rst_n_out !== eo || seq_done !== ed) begin
      errors++;
      $display("FAIL %s: got out=%b done=%b, want out=%b done=%b",
               name, rst_n_out, seq_done, eo, ed);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bit btn;
    // Reset values
    vecs.push_back('{1'b1, 1'b1, 3,  4'b0000, 1'b0});
    // Nominal release: channel i at edge 2+16+(i+1)*8
    vecs.push_back('{1'b0, 1'b1, 26, 4'b0000, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1,  4'b0001, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 7,  4'b0001, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1,  4'b0011, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 8,  4'b0111, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 7,  4'b0111, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1,  4'b1111, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 10, 4'b1111, 1'b1});
    // Assertion mid-sequence: drop at edge 38, outputs fall at edge 40
    vecs.push_back('{1'b1, 1'b1, 1,  4'b0000, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 38, 4'b0011, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1,  4'b0011, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1,  4'b0011, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1,  4'b0000, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 10, 4'b0000, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 26, 4'b0000, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1,  4'b0001, 1'b0});
    // Bounce during filter restarts it
    vecs.push_back('{1'b1, 1'b1, 1,  4'b0000, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 10, 4'b0000, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1,  4'b0000, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 26, 4'b0000, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1,  4'b0001, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 24, 4'b1111, 1'b1});
    // rst together with RST_n falling while in RUN
    vecs.push_back('{1'b1, 1'b0, 1,  4'b0000, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 5,  4'b0000, 1'b0});
    // btn_s low on the edge channel 2 would rise: assertion wins
    vecs.push_back('{1'b0, 1'b1, 40, 4'b0011, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 2,  4'b0011, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1,  4'b0000, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 5,  4'b0000, 1'b0});
    // Run to completion again
    vecs.push_back('{1'b0, 1'b1, 50, 4'b0111, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1,  4'b1111, 1'b1});

    foreach (vecs[k]) begin
      @(negedge clk);
      rst   = vecs[k].rst_v;
      RST_n = vecs[k].btn_v;
      step(vecs[k].cycles);
      check($sformatf("vec%0d", k), vecs[k].exp_out, vecs[k].exp_done);
    end

`ifdef RST_SEQ_SOFT_EN
    // Soft restart pulse from RUN: ch0 at P+25, ch3 at P+49
    @(negedge clk);
    soft_rst = 1'b1;
    step(1);
    check("soft_pulse", 4'b0000, 1'b0);
    @(negedge clk);
    soft_rst = 1'b0;
    step(23);
    check("soft_pre_ch0", 4'b0000, 1'b0);
    step(1);
    check("soft_ch0", 4'b0001, 1'b0);
    step(23);
    check("soft_pre_ch3", 4'b0111, 1'b0);
    step(1);
    check("soft_ch3", 4'b1111, 1'b1);
    @(negedge clk);
    soft_rst = 1'b1;
    step(5);
    check("soft_held", 4'b0000, 1'b0);
    @(negedge clk);
    soft_rst = 1'b0;
`endif

    // Random button activity with occasional rst, checked by the model
    btn = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (btn) btn = ($urandom_range(0, 79) != 0);
      else     btn = ($urandom_range(0, 3) == 0);
      RST_n = btn;
      rst   = ($urandom_range(0, 499) == 0);
`ifdef RST_SEQ_SOFT_EN
      soft_rst = ($urandom_range(0, 299) == 0);
`endif
    end
    @(negedge clk);
    rst = 1'b0;
    soft_rst = 1'b0;
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
